// File: rtl/onoff_arb_pkg.sv
// -----------------------------------------------------------------------------
// onoff_arb_pkg
// Shared types and helpers for the on/off round-robin arbiter.
//   state_t  : arbiter FSM states (IDLE, BUSY, COOL)
//   id_width : index width for a given count, never less than 1 bit
// -----------------------------------------------------------------------------
package onoff_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        COOL = 2'd2
    } state_t;

    // Width able to index n items; clamped to 1 so n=1/n=2 still give a usable bus.
    function automatic int id_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/onoff_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority picker. The search starts at ptr and wraps
// from N-1 back to 0; the first set request bit wins.
// Ports:
//   req    in  [N-1:0]  request vector
//   ptr    in  [W-1:0]  index where the search starts (must be < N)
//   onehot out [N-1:0]  one-hot winner, all-zero when nothing is requested
//   idx    out [W-1:0]  index of the winner, 0 when nothing is requested
//   any    out          1 when at least one request bit is set
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [N-1:0] onehot_s;
    logic [W-1:0] idx_s;
    logic         found_s;

    // Walk the requesters in rotated order and keep the first hit.
    always_comb begin
        int pos_v;
        onehot_s = '0;
        idx_s    = '0;
        found_s  = 1'b0;
        pos_v    = 0;
        for (int i = 0; i < N; i++) begin
            pos_v = int'(ptr) + i;
            if (pos_v >= N) begin
                pos_v = pos_v - N;
            end else begin
                pos_v = pos_v;
            end
            if (!found_s && req[W'(pos_v)]) begin
                found_s = 1'b1;
                idx_s   = W'(pos_v);
            end else begin
                found_s = found_s;
            end
        end
        if (found_s) begin
            onehot_s[idx_s] = 1'b1;
        end else begin
            onehot_s = '0;
        end
    end

    assign onehot = onehot_s;
    assign idx    = idx_s;
    assign any    = found_s;

endmodule

// File: rtl/onoff_rr_arbiter.sv
// -----------------------------------------------------------------------------
// onoff_rr_arbiter
// Round-robin arbiter sharing one off/on resource among N_REQ requesters.
// An owner keeps the grant while its request stays high (no preemption); after
// each ownership the resource is forced off for COOL_CYC cycles before the next
// arbitration. busy drives the resource's "on" state.
//
// Optional feature (compile-time macro ONOFF_ARB_TIMEOUT_EN): bound ownership
// to HOLD_MAX BUSY cycles; a forced release pulses timeout for one cycle.
// Without the macro timeout is tied low and ownership is unbounded.
//
// Ports:
//   clk       in            rising-edge clock
//   areset_n  in            asynchronous reset, active-low
//   req       in  [N_REQ]   level request per requester
//   gnt       out [N_REQ]   registered one-hot grant, zero when no owner
//   gnt_id    out [id_w]    index of current/last owner
//   busy      out           resource on (BUSY state)
//   timeout   out           one-cycle pulse on forced release
// -----------------------------------------------------------------------------
module onoff_rr_arbiter
    import onoff_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int COOL_CYC = 1,
    parameter int HOLD_MAX = 8
) (
    input  logic                          clk,
    input  logic                          areset_n,
    input  logic [N_REQ-1:0]              req,
    output logic [N_REQ-1:0]              gnt,
    output logic [id_width(N_REQ)-1:0]    gnt_id,
    output logic                          busy,
    output logic                          timeout
);

    localparam int ID_W = id_width(N_REQ);
    localparam int CW   = id_width(COOL_CYC);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(N_REQ - 1);
    localparam logic [CW-1:0]   COOL_LAST = CW'((COOL_CYC > 0) ? (COOL_CYC - 1) : 0);

    // Reject parameter values the arbiter cannot work with.
    if (N_REQ < 2) begin : g_bad_n_req
        $error("onoff_rr_arbiter: N_REQ must be >= 2");
    end
    if (HOLD_MAX < 1) begin : g_bad_hold_max
        $error("onoff_rr_arbiter: HOLD_MAX must be >= 1");
    end

    state_t            state_r, state_s;
    logic [ID_W-1:0]   ptr_r, ptr_s;
    logic [ID_W-1:0]   ptr_adv_s;
    logic [CW-1:0]     cool_cnt_r, cool_cnt_s;
    logic [N_REQ-1:0]  gnt_r, gnt_s;
    logic [ID_W-1:0]   gnt_id_r, gnt_id_s;
    logic              busy_r, busy_s;
    logic              leave_s;
    logic              owner_req_s;

    logic [N_REQ-1:0]  pick_onehot_s;
    logic [ID_W-1:0]   pick_idx_s;
    logic              pick_any_s;

`ifdef ONOFF_ARB_TIMEOUT_EN
    localparam int HW = id_width(HOLD_MAX);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

    logic [HW-1:0]     hold_cnt_r, hold_cnt_s;
    logic              timeout_r, timeout_s;
`endif

    rr_pick #(
        .N (N_REQ),
        .W (ID_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_r),
        .onehot (pick_onehot_s),
        .idx    (pick_idx_s),
        .any    (pick_any_s)
    );

    assign owner_req_s = req[gnt_id_r];

    // Next search start: the requester right after the owner, wrapping to 0.
    always_comb begin
        if (gnt_id_r == LAST_ID) begin
            ptr_adv_s = '0;
        end else begin
            ptr_adv_s = gnt_id_r + ID_W'(1'b1);
        end
    end

    // Next-state and next-output decode; outputs are registered from these.
    always_comb begin
        state_s    = state_r;
        ptr_s      = ptr_r;
        cool_cnt_s = cool_cnt_r;
        gnt_s      = gnt_r;
        gnt_id_s   = gnt_id_r;
        busy_s     = busy_r;
        leave_s    = 1'b0;
`ifdef ONOFF_ARB_TIMEOUT_EN
        hold_cnt_s = hold_cnt_r;
        timeout_s  = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    state_s  = BUSY;
                    gnt_s    = pick_onehot_s;
                    gnt_id_s = pick_idx_s;
                    busy_s   = 1'b1;
`ifdef ONOFF_ARB_TIMEOUT_EN
                    hold_cnt_s = '0;
`endif
                end else begin
                    gnt_s  = '0;
                    busy_s = 1'b0;
                end
            end
            BUSY: begin
                // Release has priority over the hold limit when both happen.
                if (!owner_req_s) begin
                    leave_s = 1'b1;
                end
`ifdef ONOFF_ARB_TIMEOUT_EN
                else if (hold_cnt_r == HOLD_LAST) begin
                    leave_s   = 1'b1;
                    timeout_s = 1'b1;
                end else begin
                    hold_cnt_s = hold_cnt_r + HW'(1'b1);
                end
`else
                else begin
                    leave_s = 1'b0;
                end
`endif
            end
            COOL: begin
                gnt_s  = '0;
                busy_s = 1'b0;
                if (cool_cnt_r == COOL_LAST) begin
                    state_s    = IDLE;
                    cool_cnt_s = '0;
                end else begin
                    cool_cnt_s = cool_cnt_r + CW'(1'b1);
                end
            end
            default: begin
                state_s    = IDLE;
                gnt_s      = '0;
                busy_s     = 1'b0;
                cool_cnt_s = '0;
            end
        endcase

        // Common exit from BUSY: drop the grant and move the pointer past the owner.
        if (leave_s) begin
            if (COOL_CYC == 0) begin
                state_s = IDLE;
            end else begin
                state_s = COOL;
            end
            gnt_s      = '0;
            busy_s     = 1'b0;
            ptr_s      = ptr_adv_s;
            cool_cnt_s = '0;
        end else begin
            ptr_s = ptr_s;
        end
    end

    // FSM state, pointer, cool counter and registered outputs.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_r    <= IDLE;
            ptr_r      <= '0;
            cool_cnt_r <= '0;
            gnt_r      <= '0;
            gnt_id_r   <= '0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            ptr_r      <= ptr_s;
            cool_cnt_r <= cool_cnt_s;
            gnt_r      <= gnt_s;
            gnt_id_r   <= gnt_id_s;
            busy_r     <= busy_s;
        end
    end

`ifdef ONOFF_ARB_TIMEOUT_EN
    // Hold counter and registered timeout pulse.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            hold_cnt_r <= '0;
            timeout_r  <= 1'b0;
        end else begin
            hold_cnt_r <= hold_cnt_s;
            timeout_r  <= timeout_s;
        end
    end

    assign timeout = timeout_r;
`else
    assign timeout = 1'b0;
`endif

    assign gnt    = gnt_r;
    assign gnt_id = gnt_id_r;
    assign busy   = busy_r;

endmodule
